// File: rtl/amp_seq_ctrl_if.sv
// Control/status bundle between the amplifier sequencer and its environment.
interface amp_seq_ctrl_if;
   logic       vld;
   logic       seq_low;
   logic       Flt_n;
   logic       sht_dwn;
   logic       mute;
   logic [3:0] fault_cnt;
   logic       lockout;

   modport master (output vld, seq_low, Flt_n,
                   input  sht_dwn, mute, fault_cnt, lockout);
   modport slave  (input  vld, seq_low, Flt_n,
                   output sht_dwn, mute, fault_cnt, lockout);
endinterface

// File: rtl/amp_seq_ctrl.sv
// Class-D amplifier power/mute sequencer: settle, sample-aligned unmute,
// fault retry with consecutive-fault lockout.
module amp_seq_ctrl #(
   parameter int unsigned SETTLE_CYC = 250000,
   parameter int unsigned RETRY_CYC  = 25000000,
   parameter int unsigned FLT_MAX    = 3
) (
   input  logic           clk,
   input  logic           rst_n,
   amp_seq_ctrl_if.slave  bus
);

   localparam int unsigned CNT_W  = 26;
   localparam int unsigned FCNT_W = 4;
   localparam logic [CNT_W-1:0]  SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
   localparam logic [CNT_W-1:0]  RETRY_LAST  = CNT_W'(RETRY_CYC - 1);
   localparam logic [CNT_W-1:0]  CNT_MAX     = {CNT_W{1'b1}};
   localparam logic [FCNT_W-1:0] FCNT_MAX    = {FCNT_W{1'b1}};

   typedef enum logic [2:0] {
      S_IDLE, S_SETTLE, S_UNMUTE, S_RUN, S_FAULT, S_LOCK
   } state_e;

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [FCNT_W-1:0]   fault_cnt_q, fault_cnt_d;
   logic                flt_meta_q, flt_s_q;
   logic                sht_dwn_q, sht_dwn_d;
   logic                mute_q, mute_d;
   logic                lockout_q, lockout_d;

   logic [CNT_W-1:0]    cnt_inc;
   logic [FCNT_W-1:0]   fcnt_inc;
   logic                active;

   assign cnt_inc  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
   assign fcnt_inc = (fault_cnt_q == FCNT_MAX) ? fault_cnt_q
                                               : fault_cnt_q + FCNT_W'(1);
   assign active   = (state_q == S_SETTLE) || (state_q == S_UNMUTE) ||
                     (state_q == S_RUN);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         fault_cnt_q <= '0;
         flt_meta_q  <= 1'b1;
         flt_s_q     <= 1'b1;
         sht_dwn_q   <= 1'b1;
         mute_q      <= 1'b1;
         lockout_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         fault_cnt_q <= fault_cnt_d;
         flt_meta_q  <= bus.Flt_n;
         flt_s_q     <= flt_meta_q;
         sht_dwn_q   <= sht_dwn_d;
         mute_q      <= mute_d;
         lockout_q   <= lockout_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      fault_cnt_d = fault_cnt_q;

      case (state_q)
         S_IDLE: begin
            if (bus.seq_low && flt_s_q) begin
               state_d = S_SETTLE;
               cnt_d   = '0;
            end
         end
         S_SETTLE: begin
            if (cnt_q == SETTLE_LAST) state_d = S_UNMUTE;
            else                      cnt_d   = cnt_inc;
         end
         S_UNMUTE: begin
            if (bus.vld) begin
               state_d = S_RUN;
               cnt_d   = '0;
            end
         end
         S_RUN: begin
            // Counter parks at SETTLE_LAST; reaching it marks a stable run.
            if (cnt_q == SETTLE_LAST) fault_cnt_d = '0;
            else                      cnt_d       = cnt_inc;
         end
         S_FAULT: begin
            if (!flt_s_q) begin
               cnt_d = '0;
            end else if (cnt_q == RETRY_LAST) begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         S_LOCK: ;
         default: state_d = S_IDLE;
      endcase

      // A fault outranks a queue drop, which outranks the per-state action.
      if (active) begin
         if (!flt_s_q) begin
            fault_cnt_d = fcnt_inc;
            cnt_d       = '0;
            state_d     = (32'(fcnt_inc) >= FLT_MAX) ? S_LOCK : S_FAULT;
         end else if (!bus.seq_low) begin
            state_d     = S_IDLE;
            cnt_d       = '0;
            fault_cnt_d = fault_cnt_q;
         end
      end

      sht_dwn_d = (state_d == S_IDLE) || (state_d == S_FAULT) ||
                  (state_d == S_LOCK);
      mute_d    = (state_d != S_RUN);
      lockout_d = (state_d == S_LOCK);
   end

   assign bus.sht_dwn   = sht_dwn_q;
   assign bus.mute      = mute_q;
   assign bus.fault_cnt = fault_cnt_q;
   assign bus.lockout   = lockout_q;

endmodule

// File: doc/amp_seq_ctrl.md
AMP_SEQ_CTRL -- requirements
Module: amp_seq_ctrl

Interface
REQ-001 The block SHALL have parameter SETTLE_CYC, default 250000, meaning the cycles sht_dwn is low before unmute (5 ms at 50 MHz).
REQ-002 The block SHALL have parameter RETRY_CYC, default 25000000, meaning the cycles Flt_n must stay high before a fault retry (0.5 s).
REQ-003 The block SHALL have parameter FLT_MAX, default 3, meaning the consecutive fault count that causes lockout.
REQ-004 The block SHALL have port clk, input, 1 bit: the 50 MHz system clock, and the design's one clock.
REQ-005 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-006 The block SHALL have port vld, input, 1 bit: one-cycle audio sample strobe from the I2S receiver.
REQ-007 The block SHALL have port seq_low, input, 1 bit: high when the low-frequency filter queues are full.
REQ-008 The block SHALL have port Flt_n, input, 1 bit: asynchronous active-low amplifier fault.
REQ-009 The block SHALL have port sht_dwn, output, 1 bit: amplifier shutdown, high meaning the amp is off.
REQ-010 The block SHALL have port mute, output, 1 bit: high forces the speaker driver input to zero.
REQ-011 The block SHALL have port fault_cnt, output, 4 bits: consecutive fault count.
REQ-012 The block SHALL have port lockout, output, 1 bit: high means the retry budget is exhausted.

Function
REQ-013 The block SHALL pass Flt_n through a 2-flop synchronizer (flt_s) before any use, and the synchronizer SHALL reset to 1.
REQ-014 All outputs SHALL be registered, and state SHALL be one of IDLE, SETTLE, UNMUTE, RUN, FAULT, LOCK.
REQ-015 In IDLE, the block SHALL drive sht_dwn=1 and mute=1, and SHALL go to SETTLE when seq_low=1 and flt_s=1.
REQ-016 On entering SETTLE, the block SHALL clear the shared counter and drive sht_dwn=0 and mute=1.
REQ-017 In SETTLE, the block SHALL go to UNMUTE when the counter equals SETTLE_CYC-1.
REQ-018 In UNMUTE, the block SHALL drive sht_dwn=0 and mute=1, and SHALL go to RUN on the first vld=1, so that the unmute is sample-aligned.
REQ-019 In RUN, the block SHALL drive sht_dwn=0 and mute=0.
REQ-020 In RUN, entering RUN SHALL clear fault_cnt to 0 once the counter reaches SETTLE_CYC-1 (a stable run). Before that point, fault_cnt SHALL be kept.
REQ-021 In SETTLE, UNMUTE or RUN, seq_low=0 SHALL move the block to IDLE (mute and sht_dwn both 1 on the next cycle), with fault_cnt unchanged.
REQ-022 In SETTLE, UNMUTE or RUN, flt_s=0 SHALL move the block to FAULT, take priority over seq_low=0 and vld, and increment fault_cnt (saturating at 15).
REQ-023 sht_dwn SHALL be 1 no later than 3 clk cycles after Flt_n falls.
REQ-024 In FAULT, the block SHALL drive sht_dwn=1 and mute=1.
REQ-025 In FAULT, the counter SHALL clear every cycle flt_s=0 and increment while flt_s=1.
REQ-026 In FAULT, the block SHALL go to IDLE when the counter equals RETRY_CYC-1.
REQ-027 On the fault increment, if the new fault_cnt is >= FLT_MAX, the block SHALL go to LOCK instead of FAULT.
REQ-028 LOCK SHALL drive sht_dwn=1, mute=1 and lockout=1, and SHALL be exited only by reset.
REQ-029 The counter SHALL be 26 bits wide, SHALL never wrap, and SHALL hold at its terminal value.
REQ-030 In IDLE, flt_s=0 SHALL be ignored for counting and SHALL only block the exit to SETTLE.

Reset
REQ-031 On a clk edge with rst_n=0, the block SHALL force state=IDLE, sht_dwn=1, mute=1, fault_cnt=0, lockout=0, counter=0 and synchronizer flops=1.
REQ-032 This reset behaviour SHALL apply from any state, including mid-SETTLE and LOCK, and SHALL take effect on that same edge.
REQ-033 There SHALL be no asynchronous reset path.

Verification
REQ-034 The bench SHALL use SETTLE_CYC=10, RETRY_CYC=20 and FLT_MAX=3.
REQ-035 Scenario power-up: reset, then seq_low=1 -> sht_dwn falls 1 cycle later, mute stays 1 for 10 cycles, then mute falls on the cycle after the first vld.
REQ-036 Scenario fault in RUN: Flt_n=0 for 5 cycles -> sht_dwn=1 within 3 cycles and fault_cnt=1; 20 cycles after Flt_n returns high, IDLE is re-entered and the sequence restarts.
REQ-037 Scenario glitching fault: Flt_n toggles low every 15 cycles while in FAULT -> the block never leaves FAULT (counter restarts each time).
REQ-038 Scenario lockout: 3 faults, each injected within 10 cycles of RUN entry -> lockout=1 and fault_cnt=3, sht_dwn stays 1 for 1000 cycles, and reset clears both.
REQ-039 Scenario queue drop: seq_low=0 during UNMUTE, then in RUN -> IDLE next cycle in each case, mute=1, sht_dwn=1, fault_cnt unchanged.
REQ-040 Scenario simultaneous events: Flt_n=0 and seq_low=0 in the same RUN cycle -> FAULT wins and fault_cnt increments.
